udp_tx_meta_data_gate: RTL and testbench

//   Sits on the UDP TX path, directly upstream of the 176-bit UDP meta register slice.

---
 rtl/udp_tx_meta_data_gate.sv | 140 ++++++++++++++
 tb/tb_udp_tx_meta_data_gate.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_meta_data_gate.sv
// UDP TX meta/payload gate: pairs each meta word with one tlast-delimited payload
// packet, releases payload only after meta acceptance and checks byte count vs length.
module udp_tx_meta_data_gate #(
    parameter int DATA_W = 512,
    parameter int META_W = 176,
    parameter int CNT_W  = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                s_meta_valid,
    output logic                s_meta_ready,
    input  logic [META_W-1:0]   s_meta_data,
    output logic                m_meta_valid,
    input  logic                m_meta_ready,
    output logic [META_W-1:0]   m_meta_data,
    input  logic                s_data_valid,
    output logic                s_data_ready,
    input  logic [DATA_W-1:0]   s_data_data,
    input  logic [DATA_W/8-1:0] s_data_keep,
    input  logic                s_data_last,
    output logic                m_data_valid,
    input  logic                m_data_ready,
    output logic [DATA_W-1:0]   m_data_data,
    output logic [DATA_W/8-1:0] m_data_keep,
    output logic                m_data_last,
    output logic                len_err,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                dbg_state
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int POP_W  = $clog2(KEEP_W + 1);

    typedef enum logic {S_META = 1'b0, S_DATA = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_meta_valid;
    logic [META_W-1:0]   r_meta_data;
    logic [15:0]         r_len;
    logic [16:0]         r_byte_cnt;
    logic                r_len_err;
    logic [CNT_W-1:0]    r_pkt_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                w_meta_hs;
    logic                w_data_hs;
    logic [POP_W-1:0]    w_pop;
    logic [17:0]         w_sum;
    logic [16:0]         w_total;

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both 1;
    // a source holds valid and its payload stable until that edge.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_pop = w_pop + POP_W'(s_data_keep[i]);
        end
    end

    assign w_sum   = {1'b0, r_byte_cnt} + 18'(w_pop);
    assign w_total = w_sum[17] ? 17'h1FFFF : w_sum[16:0];

    always_comb begin
        w_state_nxt  = r_state;
        s_meta_ready = 1'b0;
        s_data_ready = 1'b0;
        m_data_valid = 1'b0;
        if (!areset) begin
            case (r_state)
                S_META: begin
                    s_meta_ready = ~r_meta_valid | m_meta_ready;
                    if (s_meta_valid && s_meta_ready) begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    s_data_ready = m_data_ready;
                    m_data_valid = s_data_valid;
                    if (s_data_valid && m_data_ready && s_data_last) begin
                        w_state_nxt = S_META;
                    end
                end
            endcase
        end
    end

    assign w_meta_hs = s_meta_valid & s_meta_ready;
    assign w_data_hs = s_data_valid & s_data_ready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_META;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_meta_valid <= 1'b0;
            r_meta_data  <= '0;
            r_len        <= '0;
            r_byte_cnt   <= '0;
            r_len_err    <= 1'b0;
            r_pkt_cnt    <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_len_err <= 1'b0;
            // A reload in the same cycle as the downstream accept keeps valid high.
            if (w_meta_hs) begin
                r_meta_valid <= 1'b1;
                r_meta_data  <= s_meta_data;
                r_len        <= s_meta_data[META_W-1 -: 16];
                r_byte_cnt   <= '0;
            end else if (m_meta_ready) begin
                r_meta_valid <= 1'b0;
            end
            if (w_data_hs) begin
                r_byte_cnt <= w_total;
                if (s_data_last) begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    if (w_total != {1'b0, r_len}) begin
                        r_len_err <= 1'b1;
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign m_meta_valid = r_meta_valid;
    assign m_meta_data  = r_meta_data;
    assign m_data_data  = s_data_data;
    assign m_data_keep  = s_data_keep;
    assign m_data_last  = s_data_last;
    assign len_err      = r_len_err;
    assign pkt_cnt      = r_pkt_cnt;
    assign err_cnt      = r_err_cnt;
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_udp_tx_meta_data_gate.sv
// Bench for udp_tx_meta_data_gate: vector table, directed corner sequences and a
// randomised packet run, all checked through expected queues.
`timescale 1ns/1ps
module tb_udp_tx_meta_data_gate;
    localparam int DATA_W = 512;
    localparam int META_W = 176;
    localparam int CNT_W  = 32;
    localparam int KEEP_W = DATA_W / 8;
    localparam int TMO    = 500;
    localparam int N_RAND = 1000;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              s_meta_valid = 1'b0;
    logic              s_meta_ready;
    logic [META_W-1:0] s_meta_data = '0;
    logic              m_meta_valid;
    logic              m_meta_ready = 1'b1;
    logic [META_W-1:0] m_meta_data;
    logic              s_data_valid = 1'b0;
    logic              s_data_ready;
    logic [DATA_W-1:0] s_data_data = '0;
    logic [KEEP_W-1:0] s_data_keep = '0;
    logic              s_data_last = 1'b0;
    logic              m_data_valid;
    logic              m_data_ready = 1'b1;
    logic [DATA_W-1:0] m_data_data;
    logic [KEEP_W-1:0] m_data_keep;
    logic              m_data_last;
    logic              len_err;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              dbg_state;

    udp_tx_meta_data_gate dut (
        .aclk(aclk), .areset(areset),
        .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
        .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
        .s_data_keep(s_data_keep), .s_data_last(s_data_last),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
        .m_data_keep(m_data_keep), .m_data_last(m_data_last),
        .len_err(len_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic              l;
    } beat_t;

    typedef struct {
        int   len;
        int   n_full;
        int   last_bytes;
        logic exp_err;
    } vec_t;

    logic [META_W-1:0] exp_meta_q[$];
    beat_t             exp_data_q[$];
    logic              exp_err_q[$];
    int                n_chk = 0;
    int                n_pass = 0;
    int                exp_pkts = 0;
    int                exp_errs = 0;
    bit                abort = 1'b0;
    bit                last_pend = 1'b0;
    bit                meta_done;
    bit                data_done;
    vec_t              tbl[9];
    int                rlen[N_RAND];
    logic [META_W-1:0] meta_a;
    logic [META_W-1:0] meta_b;
    beat_t             bt;

    task automatic chk(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        else n_pass++;
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: expected event did not happen", nm);
    endtask

    function automatic logic [KEEP_W-1:0] keep_of(input int n);
        logic [KEEP_W:0] t;
        t = (65'(1) << n) - 65'(1);
        return t[KEEP_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [META_W-1:0] make_meta(input int len);
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
        r[175:160] = 16'(len);
        return r[META_W-1:0];
    endfunction

    // Output monitor: sampled on the falling edge, transfers complete on the next rise.
    always @(negedge aclk) begin
        if (last_pend) begin
            if (exp_err_q.size() > 0) chk("len_err", len_err, exp_err_q.pop_front());
            else fail("len_err_expectation");
        end else begin
            chk("len_err_idle", len_err, 0);
        end
        last_pend = !areset && m_data_valid && m_data_ready && m_data_last;
        if (!areset && m_meta_valid && m_meta_ready) begin
            if (exp_meta_q.size() > 0) chk("meta_out", m_meta_data, exp_meta_q.pop_front());
            else fail("meta_out_expectation");
        end
        if (!areset && m_data_valid && m_data_ready) begin
            if (exp_data_q.size() > 0) begin
                bt = exp_data_q.pop_front();
                chk("out_data", m_data_data, bt.d);
                chk("out_keep", m_data_keep, bt.k);
                chk("out_last", m_data_last, bt.l);
            end else begin
                fail("data_out_expectation");
            end
        end
    end

    task automatic send_meta(input logic [META_W-1:0] m, input int gap);
        int cyc;
        if (!abort) begin
            repeat (gap) begin @(posedge aclk); #1; end
            s_meta_valid = 1'b1;
            s_meta_data  = m;
            exp_meta_q.push_back(m);
            cyc = 0;
            @(negedge aclk);
            while (!s_meta_ready && cyc < TMO) begin @(negedge aclk); cyc++; end
            if (!s_meta_ready) begin fail("meta_accept_timeout"); abort = 1'b1; end
            @(posedge aclk); #1;
            s_meta_valid = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                             input logic l, input int gap);
        int cyc;
        beat_t b;
        if (!abort) begin
            repeat (gap) begin @(posedge aclk); #1; end
            s_data_valid = 1'b1;
            s_data_data  = d;
            s_data_keep  = k;
            s_data_last  = l;
            b.d = d; b.k = k; b.l = l;
            exp_data_q.push_back(b);
            cyc = 0;
            @(negedge aclk);
            while (!s_data_ready && cyc < TMO) begin @(negedge aclk); cyc++; end
            if (!s_data_ready) begin fail("data_accept_timeout"); abort = 1'b1; end
            @(posedge aclk); #1;
            s_data_valid = 1'b0;
        end
    endtask

    task automatic send_packet(input int n_full, input int last_bytes, input logic e, input bit gaps);
        exp_err_q.push_back(e);
        exp_pkts++;
        if (e) exp_errs++;
        for (int i = 0; i < n_full; i++)
            send_beat(rand_data(), '1, 1'b0, (gaps && $urandom_range(0, 3) == 0) ? 1 : 0);
        send_beat(rand_data(), keep_of(last_bytes), 1'b1, (gaps && $urandom_range(0, 3) == 0) ? 1 : 0);
    endtask

    task automatic phase_check(input string nm);
        m_meta_ready = 1'b1;
        m_data_ready = 1'b1;
        repeat (4) @(negedge aclk);
        chk({nm, "_pkt_cnt"}, pkt_cnt, exp_pkts);
        chk({nm, "_err_cnt"}, err_cnt, exp_errs);
        chk({nm, "_meta_q_empty"}, exp_meta_q.size(), 0);
        chk({nm, "_data_q_empty"}, exp_data_q.size(), 0);
        chk({nm, "_err_q_empty"}, exp_err_q.size(), 0);
        @(posedge aclk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        tbl[0] = '{100, 1, 36, 1'b0};
        tbl[1] = '{64, 1, 64, 1'b1};
        tbl[2] = '{0, 0, 0, 1'b0};
        tbl[3] = '{1, 0, 1, 1'b0};
        tbl[4] = '{200, 3, 8, 1'b0};
        tbl[5] = '{10, 0, 9, 1'b1};
        tbl[6] = '{65535, 1023, 63, 1'b0};
        tbl[7] = '{100, 1025, 36, 1'b1};   // 65636 bytes: low 16 bits alias the length
        tbl[8] = '{100, 2100, 0, 1'b1};    // count saturates, stray beats still forwarded
        for (int i = 0; i < N_RAND; i++)
            rlen[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9000) : $urandom_range(1, 256);

        // reset state, with upstream payload already presented
        s_data_valid = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_meta_ready", s_meta_ready, 0);
        chk("rst_s_data_ready", s_data_ready, 0);
        chk("rst_m_data_valid", m_data_valid, 0);
        chk("rst_m_meta_valid", m_meta_valid, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        s_data_valid = 1'b0;
        @(negedge aclk);
        chk("idle_meta_ready", s_meta_ready, 1);
        chk("idle_data_ready", s_data_ready, 0);
        @(posedge aclk); #1;

        for (int i = 0; i < 9; i++) begin
            fork
                send_meta(make_meta(tbl[i].len), 0);
                send_packet(tbl[i].n_full, tbl[i].last_bytes, tbl[i].exp_err, 1'b0);
            join
        end
        phase_check("table");

        // payload presented before its meta word
        exp_err_q.push_back(1'b0);
        exp_pkts++;
        s_data_valid = 1'b1;
        s_data_data  = rand_data();
        s_data_keep  = keep_of(8);
        s_data_last  = 1'b1;
        bt.d = s_data_data; bt.k = s_data_keep; bt.l = 1'b1;
        exp_data_q.push_back(bt);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("early_data_stall", s_data_ready, 0);
            chk("early_data_hidden", m_data_valid, 0);
            @(posedge aclk); #1;
        end
        send_meta(make_meta(8), 0);
        @(negedge aclk);
        chk("first_beat_ready", s_data_ready, 1);
        chk("first_beat_valid", m_data_valid, 1);
        @(posedge aclk); #1;
        s_data_valid = 1'b0;

        // downstream meta stall while payload flows; next meta waits for the drain
        meta_a = make_meta(100);
        meta_b = make_meta(8);
        m_meta_ready = 1'b0;
        send_meta(meta_a, 0);
        send_packet(1, 36, 1'b0, 1'b0);
        s_meta_valid = 1'b1;
        s_meta_data  = meta_b;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            chk("meta_hold_data", m_meta_data, meta_a);
            chk("meta_hold_valid", m_meta_valid, 1);
            chk("meta_b_blocked", s_meta_ready, 0);
            @(posedge aclk); #1;
        end
        exp_meta_q.push_back(meta_b);
        m_meta_ready = 1'b1;
        @(negedge aclk);
        chk("meta_b_accept", s_meta_ready, 1);
        @(posedge aclk); #1;
        s_meta_valid = 1'b0;
        send_packet(0, 8, 1'b0, 1'b0);
        phase_check("directed");

        // random throttling on every port
        meta_done = 1'b0;
        data_done = 1'b0;
        fork
            begin
                for (int i = 0; i < N_RAND; i++) send_meta(make_meta(rlen[i]), $urandom_range(0, 2));
                meta_done = 1'b1;
            end
            begin
                for (int i = 0; i < N_RAND; i++)
                    send_packet((rlen[i] - 1) / 64, rlen[i] - 64 * ((rlen[i] - 1) / 64), 1'b0, 1'b1);
                data_done = 1'b1;
            end
            begin
                while (!(meta_done && data_done)) begin
                    @(posedge aclk); #1;
                    m_meta_ready = ($urandom_range(0, 3) != 0);
                    m_data_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        phase_check("random");

        // reset after the first beat of a three-beat packet
        send_meta(make_meta(192), 0);
        send_beat(rand_data(), '1, 1'b0, 0);
        areset       = 1'b1;
        s_data_valid = 1'b1;
        s_data_data  = rand_data();
        s_data_keep  = '1;
        s_data_last  = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        exp_meta_q.delete();
        exp_data_q.delete();
        exp_err_q.delete();
        exp_pkts = 0;
        exp_errs = 0;
        @(negedge aclk);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_state", dbg_state, 0);
        chk("midrst_m_meta_valid", m_meta_valid, 0);
        chk("midrst_len_err", len_err, 0);
        chk("midrst_data_stalled", s_data_ready, 0);
        chk("midrst_data_hidden", m_data_valid, 0);
        @(posedge aclk); #1;
        s_data_valid = 1'b0;
        repeat (2) @(posedge aclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
